nibble_entry_ctrl: RTL and testbench
====================================

// Module: nibble_entry_ctrl
// PURPOSE
//  Upstream stage of the 4-bit D register. Synchronises a pushbutton and a switch bank,
//  debounces both button edges with an FSM, and on each clean press emits the captured
//  switch value on data_o with a one-cycle load_o strobe. The downstream register takes
//  data_o as d when load_o=1. Also counts accepted presses.
// PARAMETERS
//  W           4    width of switch bank / data_o
//  DB_CYCLES   4    consecutive stable synchronised cycles needed to accept a press or release (>=2)
//  CNT_W       8    width of press_cnt_o
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      reset, synchronous, active-high
//  btn_i        in   1      raw pushbutton, asynchronous, 1 = pressed
//  sw_i         in   W      raw switches, asynchronous
//  data_o       out  W      last captured switch value
//  load_o       out  1      one-cycle strobe; data_o valid with it
//  busy_o       out  1      1 while FSM is not IDLE
//  press_cnt_o  out  CNT_W  accepted presses, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: rst sampled 1 at a posedge -> next cycle state=IDLE, db_cnt=0, sync FFs=0,
//    data_o=0, load_o=0, busy_o=0, press_cnt_o=0. rst has priority over all other events,
//    including mid-debounce and a load_o in flight (a pending strobe is dropped).
//  - Sync: btn_i and sw_i each pass through 2 FFs -> btn_s, sw_s. FSM reads only btn_s/sw_s.
//  - FSM states (2-bit): IDLE=0, DB_PRESS=1, HELD=2, DB_REL=3.
//    IDLE:     btn_s=1 -> DB_PRESS, db_cnt=1; else stay.
//    DB_PRESS: btn_s=0 -> IDLE, db_cnt=0 (glitch rejected, no load).
//              btn_s=1 and db_cnt==DB_CYCLES-1 -> HELD, data_o<=sw_s, load_o<=1,
//              press_cnt_o<=press_cnt_o+1, db_cnt=0. Else db_cnt++.
//    HELD:     btn_s=0 -> DB_REL, db_cnt=1; else stay (no repeat while held).
//    DB_REL:   btn_s=1 -> HELD, db_cnt=0 (release bounce ignored).
//              btn_s=0 and db_cnt==DB_CYCLES-1 -> IDLE, db_cnt=0. Else db_cnt++.
//  - load_o registered; high exactly one cycle per accepted press, never two consecutive cycles.
//  - data_o holds its value between presses; changes only with load_o.
//  - Latency: btn_i high before posedge 0 -> btn_s high after posedge 1 -> load_o high in the
//    cycle after posedge 1+DB_CYCLES (cycle 6 for DB_CYCLES=4); data_o = sw_s sampled at that edge.
//  - sw_i changes during DB_PRESS: value at the accepting edge is captured.
//  - press_cnt_o: all-ones + accepted press -> 0, no flag.
//  - busy_o = (state != IDLE), combinational from state register.
//  - db_cnt width = $clog2(DB_CYCLES)+1; never exceeds DB_CYCLES-1.
// STRUCTURE
//  - Shared package/include lab_defs: FSM state localparams (IDLE, DB_PRESS, HELD, DB_REL)
//    and default DB_CYCLES for simulation vs board builds.
//  - Sub-module sync2 (param W): 2-FF synchroniser with sync reset; instantiated for btn_i
//    (W=1) and sw_i (W=W). FSM, debounce counter, and output registers live in the top module.
// TESTING (DB_CYCLES=4, W=4, CNT_W=8)
//  1 rst=1 for 2 cycles with btn_i=1, sw_i=4'hF -> all outputs 0, state IDLE throughout.
//  2 sw_i=4'hA, btn_i 0->1 held 20 cycles -> load_o high exactly in cycle 6, data_o=4'hA,
//    press_cnt_o=1, busy_o high from cycle 3 until 4 stable-low cycles after release.
//  3 btn_i pulses of 1,2,3 cycles separated by 5 low cycles -> load_o never asserted,
//    press_cnt_o stays 0, FSM returns to IDLE after each.
//  4 Press accepted, then release bouncing 1-0-1-0 per cycle for 6 cycles, then high 10
//    cycles -> no second load_o; state stays HELD/DB_REL, press_cnt_o unchanged.
//  5 rst=1 asserted during DB_PRESS (db_cnt=2) -> next cycle state IDLE, no load_o,
//    press_cnt_o=0; subsequent clean press with sw_i=4'h3 -> data_o=4'h3, load_o one cycle.
//  6 256 clean presses from press_cnt_o=0 -> press_cnt_o wraps to 0, load_o count = 256.

Source files
------------

// File: rtl/nibble_entry_ctrl_pkg.sv
// rtl/nibble_entry_ctrl_pkg.sv - shared FSM encodings and debounce defaults for the nibble entry stage
package nibble_entry_ctrl_pkg;

    // Debounce FSM: 2-bit encoding, values fixed so busy/state probes stay meaningful
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } state_t;

    // Short window for simulation, long window (~10 ms at 50 MHz) for the board
    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 500000;
    localparam int DB_CYCLES_DEF   = DB_CYCLES_SIM;

endpackage

// File: rtl/nibble_entry_ctrl_if.sv
// rtl/nibble_entry_ctrl_if.sv - button/switch inputs and load outputs of the nibble entry stage
interface nibble_entry_ctrl_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             btn_i;
    logic [W-1:0]     sw_i;
    logic [W-1:0]     data_o;
    logic             load_o;
    logic             busy_o;
    logic [CNT_W-1:0] press_cnt_o;

    // Board / stimulus side: drives raw inputs, observes the captured nibble
    modport master (
        output btn_i, sw_i,
        input  data_o, load_o, busy_o, press_cnt_o
    );

    // Controller side
    modport slave (
        input  btn_i, sw_i,
        output data_o, load_o, busy_o, press_cnt_o
    );
endinterface

// File: rtl/nibble_entry_ctrl_sync2.sv
// rtl/nibble_entry_ctrl_sync2.sv - two-flop synchroniser with synchronous reset
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two-stage capture of an asynchronous input; both stages clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/nibble_entry_ctrl.sv
// rtl/nibble_entry_ctrl.sv - debounced pushbutton capture of a switch nibble with load strobe
module nibble_entry_ctrl
    import nibble_entry_ctrl_pkg::*;
#(
    parameter int W         = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_entry_ctrl_if.slave   bus
);
    localparam int DB_W = $clog2(DB_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic             w_btn_s;
    logic [W-1:0]     w_sw_s;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DB_W-1:0]  r_db_cnt;
    logic [DB_W-1:0]  w_db_cnt_nxt;
    logic             w_accept;
    logic [W-1:0]     r_data;
    logic             r_load;
    logic [CNT_W-1:0] r_press_cnt;

    sync2 #(.W(1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .i_d (bus.btn_i),
        .o_q (w_btn_s)
    );

    sync2 #(.W(W)) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .i_d (bus.sw_i),
        .o_q (w_sw_s)
    );

    // Next-state / debounce counter; w_accept marks the edge a press becomes valid
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt  = ST_DB_PRESS;
                    w_db_cnt_nxt = DB_W'(1);
                end
            end
            ST_DB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_nxt  = ST_IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = ST_HELD;
                    w_db_cnt_nxt = '0;
                    w_accept     = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt  = ST_DB_REL;
                    w_db_cnt_nxt = DB_W'(1);
                end
            end
            ST_DB_REL: begin
                if (w_btn_s) begin
                    w_state_nxt  = ST_HELD;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_db_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    // State, counter and output registers; reset drops any strobe about to fire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_db_cnt    <= '0;
            r_data      <= '0;
            r_load      <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
            r_load   <= w_accept;
            if (w_accept) begin
                r_data      <= w_sw_s;
                r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.data_o      = r_data;
    assign bus.load_o      = r_load;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.press_cnt_o = r_press_cnt;
endmodule

// File: tb/tb_nibble_entry_ctrl.sv
// tb/tb_nibble_entry_ctrl.sv - self-checking bench for nibble_entry_ctrl
module tb_nibble_entry_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nibble_entry_ctrl_if #(.W(4), .CNT_W(8)) bus ();

    nibble_entry_ctrl #(.W(4), .DB_CYCLES(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         load_count = 0;
    logic       prev_load = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    // Scoreboard monitor: every strobe must match the oldest expected press
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.load_o) begin
                exp_t e;
                load_count++;
                checks++;
                if (prev_load) begin
                    errors++;
                    $display("FAIL load_double: load_o high on two consecutive cycles");
                end
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_unexpected: load_o=1 data_o=%h with no press expected", bus.data_o);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (bus.data_o !== e.data || bus.press_cnt_o !== e.cnt) begin
                        errors++;
                        $display("FAIL sb_load: data_o=%h press_cnt_o=%0d expected data %h cnt %0d",
                                 bus.data_o, bus.press_cnt_o, e.data, e.cnt);
                    end
                end
            end
            prev_load = bus.load_o;
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_press(input logic [3:0] v);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.data = v;
        e.cnt  = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected strobes never seen, required 0", name, sb_q.size());
        end
    endtask

    task automatic press_clean(input logic [3:0] v);
        bus.sw_i  = v;
        bus.btn_i = 1'b1;
        expect_press(v);
        repeat (7) tick();
        bus.btn_i = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.btn_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_i = 1'b1;
        bus.sw_i  = 4'hF;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.data_o !== 4'h0 || bus.load_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.press_cnt_o !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs: data=%h load=%b busy=%b cnt=%0d required all 0",
                         bus.data_o, bus.load_o, bus.busy_o, bus.press_cnt_o);
            end
        end
        bus.btn_i = 1'b0;
        bus.sw_i  = 4'h0;
        rst = 1'b0;
        exp_cnt = 8'd0;
        repeat (3) tick();
    endtask

    task automatic test_press_latency();
        bus.sw_i = 4'hA;
        repeat (3) tick();
        bus.btn_i = 1'b1;
        expect_press(4'hA);
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (bus.load_o !== (c == 5) || bus.busy_o !== (c >= 2)) begin
                errors++;
                $display("FAIL press_timing c%0d: load=%b busy=%b required load=%b busy=%b",
                         c, bus.load_o, bus.busy_o, (c == 5), (c >= 2));
            end
        end
        checks++;
        if (bus.data_o !== 4'hA || bus.press_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL press_value: data=%h cnt=%0d required A 1", bus.data_o, bus.press_cnt_o);
        end
        bus.btn_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.busy_o !== (c < 5)) begin
                errors++;
                $display("FAIL release_busy c%0d: busy=%b required %b", c, bus.busy_o, (c < 5));
            end
        end
        check_sb_empty("press_sb");
    endtask

    task automatic test_glitch();
        for (int w = 1; w <= 3; w++) begin
            bus.sw_i  = 4'(w + 4);
            bus.btn_i = 1'b1;
            repeat (w) tick();
            bus.btn_i = 1'b0;
            repeat (5) tick();
            repeat (2) tick();
            checks++;
            if (bus.busy_o !== 1'b0 || bus.press_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL glitch_w%0d: busy=%b cnt=%0d required 0 %0d", w, bus.busy_o, bus.press_cnt_o, exp_cnt);
            end
        end
        check_sb_empty("glitch_sb");
    endtask

    task automatic test_release_bounce();
        logic seen = 1'b0;
        bus.sw_i  = 4'h5;
        bus.btn_i = 1'b1;
        expect_press(4'h5);
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = bus.load_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bounce_accept_timeout: load_o=0 within 20 cycles, required 1");
        end
        repeat (3) tick();
        for (int c = 0; c < 16; c++) begin
            bus.btn_i = (c < 6) ? c[0] : 1'b1;
            tick();
            checks++;
            if (bus.busy_o !== 1'b1 || bus.press_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL bounce_hold c%0d: busy=%b cnt=%0d required 1 %0d", c, bus.busy_o, bus.press_cnt_o, exp_cnt);
            end
        end
        bus.btn_i = 1'b0;
        repeat (8) tick();
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: busy=%b required 0", bus.busy_o);
        end
        check_sb_empty("bounce_sb");
    endtask

    task automatic test_reset_mid_debounce();
        bus.sw_i  = 4'hC;
        bus.btn_i = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_db_busy: busy=%b required 1", bus.busy_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.load_o !== 1'b0 || bus.press_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL mid_db_reset: busy=%b load=%b cnt=%0d required 0 0 0", bus.busy_o, bus.load_o, bus.press_cnt_o);
        end
        rst = 1'b0;
        bus.btn_i = 1'b0;
        exp_cnt = 8'd0;
        sb_q.delete();
        repeat (4) tick();
        press_clean(4'h3);
        checks++;
        if (bus.data_o !== 4'h3 || bus.press_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_press: data=%h cnt=%0d required 3 1", bus.data_o, bus.press_cnt_o);
        end
        check_sb_empty("post_reset_sb");
    endtask

    task automatic test_back_to_back_wrap();
        int start_loads;
        do_reset();
        repeat (2) tick();
        start_loads = load_count;
        for (int i = 0; i < 256; i++) begin
            press_clean(4'($urandom_range(0, 15)));
        end
        checks++;
        if (bus.press_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL wrap_cnt: press_cnt_o=%0d required 0", bus.press_cnt_o);
        end
        checks++;
        if (load_count - start_loads != 256) begin
            errors++;
            $display("FAIL wrap_loads: load strobes=%0d required 256", load_count - start_loads);
        end
        check_sb_empty("wrap_sb");
    endtask

    initial begin
        bus.btn_i = 1'b0;
        bus.sw_i  = 4'h0;
        test_reset();
        test_press_latency();
        test_glitch();
        test_release_bounce();
        test_reset_mid_debounce();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
